// File: rtl/seq_mult_handshake.sv
// Iterative shift-add multiplier: one multiplier bit per clock, valid/ready on both sides.
// Signed mode multiplies magnitudes and negates the final product, so latency is data-independent.
module seq_mult_handshake #(
  parameter  int WIDTH = 16,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 is_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   c,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   cnt;
  logic               neg;

  logic               accept;
  logic               last_iter;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic               neg_in;
  logic [2*WIDTH-1:0] acc_sum;

  assign accept    = in_valid & in_ready;
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  // Magnitudes stay WIDTH bits wide: the most-negative value maps to 2^(WIDTH-1).
  assign a_mag  = (is_signed && a[WIDTH-1]) ? -a : a;
  assign b_mag  = (is_signed && b[WIDTH-1]) ? -b : b;
  assign neg_in = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);

  assign acc_sum = acc + (mplier[0] ? mcand : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid) state_nxt = RUN;
      RUN:     if (last_iter) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state)
      IDLE: in_ready = 1'b1;
      RUN:  busy = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: in_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
    end else if (accept) begin
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, a_mag};
      mplier <= b_mag;
      cnt    <= '0;
      neg    <= neg_in;
    end else if (state == RUN) begin
      acc    <= acc_sum;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CNT_W'(1);
    end
  end

  // c only changes on the final iteration, so it holds through DONE and after consumption.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c <= '0;
    end else if (state == RUN && last_iter) begin
      c <= neg ? -acc_sum : acc_sum;
    end
  end

endmodule
